merge_arb11: RTL and testbench

//  Two-input merge stage of the router output port; sits directly downstream of
//  the split stage. Accepts 11-bit flits from two channels, arbitrates between

---
 rtl/merge_arb11.sv | 104 ++++++++++
 tb/tb_merge_arb11.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/merge_arb11.sv
// merge_arb11: two-input flit merge with arbitration feeding a small output FIFO.
// Optional build macro MERGE_RR_EN selects round-robin contention (default: in1 fixed priority).
`default_nettype none

module merge_arb11 #(
    parameter int WIDTH = 11,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in1_data,
    input  logic             in1_valid,
    output logic             in1_ready,
    input  logic [WIDTH-1:0] in2_data,
    input  logic             in2_valid,
    output logic             in2_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] r_storage [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;

    logic             w_full;
    logic             w_empty;
    logic             w_pick1;
    logic             w_pick2;
    logic             w_push;
    logic             w_pop;
    logic [WIDTH-1:0] w_push_data;

    assign w_full  = (r_count == CW'(DEPTH));
    assign w_empty = (r_count == '0);

`ifdef MERGE_RR_EN
    // 1 when the most recent push came from in2; reset value lets in1 win first.
    logic r_last_in2;

    assign w_pick2 = in2_valid & (~in1_valid | ~r_last_in2);
`else
    assign w_pick2 = in2_valid & ~in1_valid;
`endif
    assign w_pick1 = in1_valid & ~w_pick2;

    // A pop in the same cycle never frees a slot for a full FIFO, keeping readies off the output path.
    assign in1_ready = w_pick1 & ~w_full & reset;
    assign in2_ready = w_pick2 & ~w_full & reset;

    assign w_push      = (in1_valid & in1_ready) | (in2_valid & in2_ready);
    assign w_push_data = w_pick2 ? in2_data : in1_data;
    assign w_pop       = out_valid & out_ready;

    assign out_valid = ~w_empty;
    assign out_data  = r_storage[r_rd_ptr];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_storage[i] <= '0;
            end
            r_wr_ptr <= '0;
        end else if (w_push) begin
            r_storage[r_wr_ptr] <= w_push_data;
            r_wr_ptr <= (r_wr_ptr == PW'(DEPTH - 1)) ? '0 : r_wr_ptr + PW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rd_ptr <= '0;
        end else if (w_pop) begin
            r_rd_ptr <= (r_rd_ptr == PW'(DEPTH - 1)) ? '0 : r_rd_ptr + PW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count <= '0;
        end else if (w_push && !w_pop) begin
            r_count <= r_count + CW'(1);
        end else if (w_pop && !w_push) begin
            r_count <= r_count - CW'(1);
        end
    end

`ifdef MERGE_RR_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_last_in2 <= 1'b1;
        end else if (w_push) begin
            r_last_in2 <= w_pick2;
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_merge_arb11.sv
// tb_merge_arb11: directed self-checking bench for merge_arb11 (either MERGE_RR_EN build).
`default_nettype none

module tb_merge_arb11;

    logic        clk;
    logic        reset;
    logic [10:0] in1_data;
    logic        in1_valid;
    logic        in1_ready;
    logic [10:0] in2_data;
    logic        in2_valid;
    logic        in2_ready;
    logic [10:0] out_data;
    logic        out_valid;
    logic        out_ready;

    int n_cmp;
    int n_err;

    merge_arb11 #(.WIDTH(11), .DEPTH(2)) dut (
        .clk      (clk),
        .reset    (reset),
        .in1_data (in1_data),
        .in1_valid(in1_valid),
        .in1_ready(in1_ready),
        .in2_data (in2_data),
        .in2_valid(in2_valid),
        .in2_ready(in2_ready),
        .out_data (out_data),
        .out_valid(out_valid),
        .out_ready(out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        in1_valid = 1'b0;
        in2_valid = 1'b0;
        in1_data  = '0;
        in2_data  = '0;
        out_ready = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        @(posedge clk);
        #2;
        reset = 1'b0;
        #4;
        reset = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;
        in1_valid = 1'b1;
        in2_valid = 1'b1;
        in1_data  = 11'h123;
        in2_data  = 11'h456;
        out_ready = 1'b1;
        #1;
        n_cmp++; if (in1_ready !== 1'b0) begin n_err++; $display("FAIL reset_in1_ready got=%b exp=0", in1_ready); end
        n_cmp++; if (in2_ready !== 1'b0) begin n_err++; $display("FAIL reset_in2_ready got=%b exp=0", in2_ready); end
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        n_cmp++; if (out_data !== 11'h000) begin n_err++; $display("FAIL reset_out_data got=%h exp=000", out_data); end
        tick();
        n_cmp++; if (in1_ready !== 1'b0) begin n_err++; $display("FAIL reset_held_in1_ready got=%b exp=0", in1_ready); end
        reset = 1'b1;
        #1;
        n_cmp++; if (in1_ready !== 1'b1) begin n_err++; $display("FAIL release_in1_ready got=%b exp=1", in1_ready); end
        n_cmp++; if (in2_ready !== 1'b0) begin n_err++; $display("FAIL release_in2_ready got=%b exp=0", in2_ready); end
        do_reset();
    endtask

    task automatic test_single();
        in1_valid = 1'b1;
        in1_data  = 11'b10111000111;
        out_ready = 1'b1;
        #1;
        n_cmp++; if (in1_ready !== 1'b1) begin n_err++; $display("FAIL single_in1_ready got=%b exp=1", in1_ready); end
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL single_pre_out_valid got=%b exp=0", out_valid); end
        tick();
        in1_valid = 1'b0;
        #1;
        n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL single_out_valid got=%b exp=1", out_valid); end
        n_cmp++; if (out_data !== 11'b10111000111) begin n_err++; $display("FAIL single_out_data got=%h exp=5c7", out_data); end
        tick();
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL single_drain_out_valid got=%b exp=0", out_valid); end
    endtask

    task automatic test_contention();
        logic [10:0] exp_out [4];
        logic        exp_g2  [4];
`ifdef MERGE_RR_EN
        exp_out = '{11'h001, 11'h7FF, 11'h001, 11'h7FF};
        exp_g2  = '{1'b0, 1'b1, 1'b0, 1'b1};
`else
        exp_out = '{11'h001, 11'h001, 11'h001, 11'h001};
        exp_g2  = '{1'b0, 1'b0, 1'b0, 1'b0};
`endif
        in1_valid = 1'b1;
        in2_valid = 1'b1;
        in1_data  = 11'h001;
        in2_data  = 11'h7FF;
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            n_cmp++; if (in2_ready !== exp_g2[k]) begin n_err++; $display("FAIL contend_in2_ready[%0d] got=%b exp=%b", k, in2_ready, exp_g2[k]); end
            n_cmp++; if (in1_ready !== ~exp_g2[k]) begin n_err++; $display("FAIL contend_in1_ready[%0d] got=%b exp=%b", k, in1_ready, ~exp_g2[k]); end
            tick();
            n_cmp++; if (out_data !== exp_out[k] || out_valid !== 1'b1) begin n_err++; $display("FAIL contend_out[%0d] got=%b/%h exp=1/%h", k, out_valid, out_data, exp_out[k]); end
        end
        in1_valid = 1'b0;
        in2_valid = 1'b0;
        tick();
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL contend_drain got=%b exp=0", out_valid); end
    endtask

    task automatic test_fill_order();
        out_ready = 1'b0;
        in1_valid = 1'b1;
        in1_data  = 11'h03D;
        #1;
        n_cmp++; if (in1_ready !== 1'b1) begin n_err++; $display("FAIL fill_ready0 got=%b exp=1", in1_ready); end
        tick();
        in1_data = 11'h000;
        #1;
        n_cmp++; if (in1_ready !== 1'b1) begin n_err++; $display("FAIL fill_ready1 got=%b exp=1", in1_ready); end
        tick();
        in1_data = 11'h155;
        #1;
        n_cmp++; if (in1_ready !== 1'b0) begin n_err++; $display("FAIL fill_full_ready got=%b exp=0", in1_ready); end
        tick();
        n_cmp++; if (out_valid !== 1'b1 || out_data !== 11'h03D) begin n_err++; $display("FAIL fill_hold got=%b/%h exp=1/03d", out_valid, out_data); end
        out_ready = 1'b1;
        #1;
        n_cmp++; if (in1_ready !== 1'b0) begin n_err++; $display("FAIL fill_pop_ready got=%b exp=0", in1_ready); end
        tick();
        n_cmp++; if (out_data !== 11'h000) begin n_err++; $display("FAIL fill_out1 got=%h exp=000", out_data); end
        n_cmp++; if (in1_ready !== 1'b1) begin n_err++; $display("FAIL fill_ready_after_pop got=%b exp=1", in1_ready); end
        tick();
        in1_valid = 1'b0;
        #1;
        n_cmp++; if (out_valid !== 1'b1 || out_data !== 11'h155) begin n_err++; $display("FAIL fill_out2 got=%b/%h exp=1/155", out_valid, out_data); end
        tick();
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL fill_drain got=%b exp=0", out_valid); end
    endtask

    task automatic test_full_pop();
        out_ready = 1'b0;
        in1_valid = 1'b1;
        in1_data  = 11'h0AA;
        tick();
        in1_data = 11'h0BB;
        tick();
        in1_valid = 1'b0;
        in2_valid = 1'b1;
        in2_data  = 11'h0CC;
        out_ready = 1'b1;
        #1;
        n_cmp++; if (in2_ready !== 1'b0) begin n_err++; $display("FAIL fullpop_in2_ready got=%b exp=0", in2_ready); end
        n_cmp++; if (out_data !== 11'h0AA) begin n_err++; $display("FAIL fullpop_head got=%h exp=0aa", out_data); end
        tick();
        n_cmp++; if (in2_ready !== 1'b1) begin n_err++; $display("FAIL fullpop_in2_next got=%b exp=1", in2_ready); end
        n_cmp++; if (out_data !== 11'h0BB) begin n_err++; $display("FAIL fullpop_out1 got=%h exp=0bb", out_data); end
        tick();
        in2_valid = 1'b0;
        #1;
        n_cmp++; if (out_valid !== 1'b1 || out_data !== 11'h0CC) begin n_err++; $display("FAIL fullpop_out2 got=%b/%h exp=1/0cc", out_valid, out_data); end
        tick();
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL fullpop_drain got=%b exp=0", out_valid); end
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        in2_valid = 1'b1;
        in2_data  = 11'h2A5;
        tick();
        in2_data = 11'h35A;
        tick();
        in2_valid = 1'b0;
        #1;
        n_cmp++; if (out_valid !== 1'b1 || out_data !== 11'h2A5) begin n_err++; $display("FAIL mid_pre got=%b/%h exp=1/2a5", out_valid, out_data); end
        reset = 1'b0;
        #1;
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL mid_async_valid got=%b exp=0", out_valid); end
        n_cmp++; if (out_data !== 11'h000) begin n_err++; $display("FAIL mid_async_data got=%h exp=000", out_data); end
        #1;
        reset = 1'b1;
        out_ready = 1'b1;
        tick();
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL mid_after_release got=%b exp=0", out_valid); end
        in2_valid = 1'b1;
        in2_data  = 11'h111;
        #1;
        n_cmp++; if (in2_ready !== 1'b1) begin n_err++; $display("FAIL mid_first_grant got=%b exp=1", in2_ready); end
        tick();
        in2_valid = 1'b0;
        #1;
        n_cmp++; if (out_data !== 11'h111 || out_valid !== 1'b1) begin n_err++; $display("FAIL mid_first_flit got=%b/%h exp=1/111", out_valid, out_data); end
        tick();
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        reset = 1'b0;
        idle_inputs();
        repeat (2) @(posedge clk);
        test_reset();
        test_single();
        do_reset();
        test_contention();
        do_reset();
        test_fill_order();
        do_reset();
        test_full_pop();
        do_reset();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
